// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS datapath stages.
package mips_pkg;

    localparam int WORD_BYTES = 4;
    localparam int PC_INCR    = 4;
    localparam logic [31:0] RESET_PC = 32'h8002_0000;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/instr_mem.sv
// Read-only instruction store with an asynchronous read port.
// Contents come from simulation preload only; there is no write port.
module instr_mem #(
    parameter int data_width = 32,
    parameter int mem_depth  = 262144
) (
    input  logic [$clog2(mem_depth)-1:0] addr,
    output logic [data_width-1:0]        rdata
);

    // Deliberately left uninitialised so a bench preload is never overwritten.
    logic [data_width-1:0] mem [0:mem_depth-1];

    assign rdata = mem[addr];

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: free-running PC stepping one word per clock,
// addressing a private instruction memory with zero-cycle read latency.
module fetch
    import mips_pkg::*;
#(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int mem_depth     = 262144,
    parameter logic [address_width-1:0] base_address = RESET_PC
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [data_width-1:0] instr
);

    localparam int IDX_W = $clog2(mem_depth);

    logic [address_width-1:0] pc;
    logic [address_width-1:0] pc_d;
    logic [IDX_W-1:0]         idx;

    always_comb begin
        pc_d = pc + address_width'(PC_INCR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= base_address;
        end else begin
            pc <= pc_d;
        end
    end

    // Offset from base wraps modulo 2^address_width, so PCs below base and
    // past the end both fold back into the array without any error flag.
    assign idx = IDX_W'(((pc - base_address) >> 2) % address_width'(mem_depth));

    instr_mem #(
        .data_width (data_width),
        .mem_depth  (mem_depth)
    ) mem_inst (
        .addr  (idx),
        .rdata (instr)
    );

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: PC stepping, async reset and
// memory-index wrap, checked against a simple count-of-edges model.
module tb_fetch;

    localparam logic [31:0] BASE       = 32'h8002_0000;
    localparam int          BIG_DEPTH  = 262144;
    localparam int          SMALL_DEPTH = 64;
    localparam int          MODEL_WORDS = 512;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] instr_s;

    int n_checks;
    int n_fail;
    int n;                       // rising edges since reset release

    logic [31:0] exp_big   [0:MODEL_WORDS-1];
    logic [31:0] exp_small [0:SMALL_DEPTH-1];

    fetch #(
        .data_width    (32),
        .address_width (32),
        .mem_depth     (BIG_DEPTH),
        .base_address  (BASE)
    ) fetch_inst (
        .clock (clock),
        .reset (reset),
        .instr (instr)
    );

    fetch #(
        .data_width    (32),
        .address_width (32),
        .mem_depth     (SMALL_DEPTH),
        .base_address  (BASE)
    ) fetch_small (
        .clock (clock),
        .reset (reset),
        .instr (instr_s)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] model_pc(input int edges);
        return BASE + 32'(edges) * 32'd4;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        if (!reset) n++;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        n = 0;
        #2;
        for (int e = 0; e < 3; e++) begin
            step();
            n_checks++;
            if (fetch_inst.pc !== BASE) begin
                n_fail++;
                $display("FAIL reset_pc edge %0d: got %h want %h", e, fetch_inst.pc, BASE);
            end
            n_checks++;
            if (instr !== 32'h1000_0000) begin
                n_fail++;
                $display("FAIL reset_instr edge %0d: got %h want %h", e, instr, 32'h1000_0000);
            end
        end
    endtask

    task automatic test_sequential();
        release_reset();
        for (int e = 1; e <= 56; e++) begin
            step();
            n_checks++;
            if (fetch_inst.pc !== model_pc(n)) begin
                n_fail++;
                $display("FAIL seq_pc edge %0d: got %h want %h", e, fetch_inst.pc, model_pc(n));
            end
            n_checks++;
            if (instr !== exp_big[n]) begin
                n_fail++;
                $display("FAIL seq_instr edge %0d: got %h want %h", e, instr, exp_big[n]);
            end
        end
        n_checks++;
        if (fetch_inst.pc !== 32'h8002_00E0 || instr !== 32'h1000_0038) begin
            n_fail++;
            $display("FAIL seq_edge56: got pc %h instr %h want 800200e0 10000038", fetch_inst.pc, instr);
        end
    endtask

    task automatic test_async_reset();
        reset = 1'b1;
        #3;
        release_reset();
        repeat (4) step();
        n_checks++;
        if (fetch_inst.pc !== 32'h8002_0010) begin
            n_fail++;
            $display("FAIL async_pre_pc: got %h want 80020010", fetch_inst.pc);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (fetch_inst.pc !== BASE) begin
            n_fail++;
            $display("FAIL async_pc: got %h want %h", fetch_inst.pc, BASE);
        end
        n_checks++;
        if (instr !== exp_big[0]) begin
            n_fail++;
            $display("FAIL async_instr: got %h want %h", instr, exp_big[0]);
        end
        release_reset();
        step();
        n_checks++;
        if (fetch_inst.pc !== 32'h8002_0004 || instr !== exp_big[1]) begin
            n_fail++;
            $display("FAIL async_release: got pc %h instr %h want 80020004 %h", fetch_inst.pc, instr, exp_big[1]);
        end
    endtask

    task automatic test_reset_at_edge();
        repeat (5) step();
        @(posedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (fetch_inst.pc !== BASE || instr !== exp_big[0]) begin
            n_fail++;
            $display("FAIL edge_reset: got pc %h instr %h want %h %h", fetch_inst.pc, instr, BASE, exp_big[0]);
        end
        step();
        n_checks++;
        if (fetch_inst.pc !== BASE) begin
            n_fail++;
            $display("FAIL edge_reset_hold: got %h want %h", fetch_inst.pc, BASE);
        end
        release_reset();
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        #2;
        release_reset();
        for (int e = 1; e <= SMALL_DEPTH + 3; e++) begin
            step();
            n_checks++;
            if (fetch_small.pc !== model_pc(n) || instr_s !== exp_small[n % SMALL_DEPTH]) begin
                n_fail++;
                $display("FAIL wrap edge %0d: got pc %h instr %h want %h %h", e, fetch_small.pc, instr_s,
                         model_pc(n), exp_small[n % SMALL_DEPTH]);
            end
            n_checks++;
            if (instr !== exp_big[n]) begin
                n_fail++;
                $display("FAIL wrap_big edge %0d: got %h want %h", e, instr, exp_big[n]);
            end
        end
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 8; it++) begin
            int len;
            len = int'($urandom_range(1, 150));
            for (int e = 0; e < len; e++) begin
                step();
                n_checks++;
                if (fetch_inst.pc !== model_pc(n) || instr !== exp_big[n]) begin
                    n_fail++;
                    $display("FAIL rand_run it %0d edge %0d: got pc %h instr %h want %h %h", it, n,
                             fetch_inst.pc, instr, model_pc(n), exp_big[n]);
                end
            end
            if ($urandom_range(0, 1) == 0) begin
                #($urandom_range(1, 8));
                reset = 1'b1;
            end else begin
                @(posedge clock);
                reset = 1'b1;
            end
            #1;
            n_checks++;
            if (fetch_inst.pc !== BASE || instr !== exp_big[0]) begin
                n_fail++;
                $display("FAIL rand_reset it %0d: got pc %h instr %h want %h %h", it, fetch_inst.pc, instr,
                         BASE, exp_big[0]);
            end
            release_reset();
        end
    endtask

    task automatic test_image();
        for (int k = 0; k < 64; k++) begin
            exp_big[k] = $urandom;
            fetch_inst.mem_inst.mem[k] = exp_big[k];
        end
        reset = 1'b1;
        #2;
        release_reset();
        #1;
        for (int e = 0; e < 40; e++) begin
            $display("PC / Content: %h / %h", fetch_inst.pc, instr);
            n_checks++;
            if (fetch_inst.pc !== model_pc(n) || instr !== exp_big[n]) begin
                n_fail++;
                $display("FAIL image word %0d: got pc %h instr %h want %h %h", n, fetch_inst.pc, instr,
                         model_pc(n), exp_big[n]);
            end
            step();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n        = 0;
        reset    = 1'b1;
        for (int k = 0; k < MODEL_WORDS; k++) begin
            exp_big[k] = 32'h1000_0000 + 32'(k);
            fetch_inst.mem_inst.mem[k] = exp_big[k];
        end
        for (int k = 0; k < SMALL_DEPTH; k++) begin
            exp_small[k] = 32'h2000_0000 + 32'(k);
            fetch_small.mem_inst.mem[k] = exp_small[k];
        end

        test_reset();
        test_sequential();
        test_async_reset();
        test_reset_at_edge();
        test_wrap();
        test_random_runs();
        test_image();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
